mmio_bus_decoder: RTL and testbench

MMIO_BUS_DECODER -- requirements
Module: mmio_bus_decoder

---
 rtl/mmio_pkg.sv | 21 ++
 rtl/mmio_timeout_ctr.sv | 36 +++
 rtl/mmio_bus_decoder.sv | 182 ++++++++++++++++++
 tb/tb_mmio_bus_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared types and constants for the MMIO bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  localparam int unsigned c_data_w      = 32;
  localparam int unsigned c_addr_w      = 32;
  localparam int unsigned c_cnt_w       = 8;
  localparam int unsigned c_def_timeout = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mmio_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timeout_ctr
// Description : Counts stalled WAIT cycles and flags expiry after TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timeout_ctr
  import mmio_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_def_timeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [c_cnt_w-1:0] r_count;

  // Expired is asserted in the TIMEOUT-th enabled cycle, so the caller
  // leaves WAIT after exactly TIMEOUT cycles without an ack.
  assign expired = enable && (r_count >= c_cnt_w'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_decoder
// Description : CPU-to-slave MMIO decoder with slave timeout and bus errors.
//               Define DECODE_ERR_CAPTURE_EN to add err_addr/err_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bus_decoder
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_LSB    = 7,
  parameter int unsigned SEL_BITS   = 2,
  parameter int unsigned TIMEOUT    = c_def_timeout
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [c_addr_w-1:0]          cpu_addr,
  input  logic [c_data_w-1:0]          cpu_wdata,
  output logic [c_data_w-1:0]          cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_we,
  output logic [c_addr_w-1:0]          s_addr,
  output logic [c_data_w-1:0]          s_wdata,
  input  logic [NUM_SLAVES*c_data_w-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ack
`ifdef DECODE_ERR_CAPTURE_EN
  ,
  output logic [c_addr_w-1:0]          err_addr,
  output logic [c_cnt_w-1:0]           err_cnt
`endif
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_BITS-1:0]   w_sel;
  logic                  w_mapped;
  logic [NUM_SLAVES-1:0] w_sel_onehot;
  logic                  w_ack;
  logic [c_data_w-1:0]   w_sel_rdata;
  logic                  w_expired;
  logic                  w_accept;
  logic                  w_unmapped;
  logic                  w_done_ok;
  logic                  w_timeout;

  logic [SEL_BITS-1:0]   r_sel;
  logic [NUM_SLAVES-1:0] r_s_req;
  logic                  r_s_we;
  logic [c_addr_w-1:0]   r_s_addr;
  logic [c_data_w-1:0]   r_s_wdata;
  logic [c_data_w-1:0]   r_rdata;
  logic                  r_err;

  assign w_sel    = cpu_addr[SEL_LSB +: SEL_BITS];
  assign w_mapped = (32'(w_sel) < NUM_SLAVES);

  // Decode on the live address for the request, on the latched select
  // for ack/read data so other slaves' acks are ignored.
  always_comb begin
    w_sel_onehot = '0;
    w_ack        = 1'b0;
    w_sel_rdata  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      w_sel_onehot[i] = (w_sel == SEL_BITS'(i));
      if (r_sel == SEL_BITS'(i)) begin
        w_ack       = s_ack[i];
        w_sel_rdata = s_rdata[c_data_w*i +: c_data_w];
      end
    end
  end

  mmio_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_accept),
    .enable  (r_state == WAIT),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_unmapped  = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (w_mapped) begin
            w_accept    = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_unmapped  = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (w_ack) begin
          w_done_ok   = 1'b1;
          w_state_nxt = RESP;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_s_req   <= '0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sel     <= w_sel;
        r_s_req   <= w_sel_onehot;
        r_s_we    <= cpu_we;
        r_s_addr  <= cpu_addr;
        r_s_wdata <= cpu_wdata;
      end
      if (w_done_ok || w_timeout) begin
        r_s_req <= '0;
      end
      if (w_unmapped || w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else if (w_done_ok) begin
        r_rdata <= r_s_we ? '0 : w_sel_rdata;
        r_err   <= 1'b0;
      end
    end
  end

  assign cpu_ready = (r_state == RESP);
  assign cpu_err   = cpu_ready && r_err;
  assign cpu_rdata = cpu_ready ? r_rdata : '0;
  assign s_req     = r_s_req;
  assign s_we      = r_s_we;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;

`ifdef DECODE_ERR_CAPTURE_EN
  logic [c_addr_w-1:0] r_err_addr;
  logic [c_cnt_w-1:0]  r_err_cnt;

  // Unmapped faults were never latched into s_addr, so take the live address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else if (w_unmapped || w_timeout) begin
      r_err_addr <= w_unmapped ? cpu_addr : r_s_addr;
      if (r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err_addr = r_err_addr;
  assign err_cnt  = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bus_decoder
// Description : Self-checking bench for mmio_bus_decoder (3 slaves, TIMEOUT 15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_decoder;

  localparam int NS = 3;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic [NS-1:0]     s_req;
  logic              s_we;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [NS*32-1:0]  s_rdata;
  logic [NS-1:0]     s_ack = '0;
`ifdef DECODE_ERR_CAPTURE_EN
  logic [31:0]       err_addr;
  logic [7:0]        err_cnt;
  int                exp_ecnt = 0;
  logic [31:0]       exp_eaddr = '0;
`endif

  logic [31:0] sdata [NS];
  assign s_rdata = {sdata[2], sdata[1], sdata[0]};

  mmio_bus_decoder #(
    .NUM_SLAVES (NS),
    .SEL_LSB    (7),
    .SEL_BITS   (2),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .s_req     (s_req),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack)
`ifdef DECODE_ERR_CAPTURE_EN
    ,
    .err_addr  (err_addr),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Current transaction as seen by the model: timeline relative to t_start,
  // the cycle in which the decoder samples the request while idle.
  bit          t_active = 1'b0;
  int          t_start = 0;
  int          t_lat = 0;
  int          t_ackd = 0;
  int          t_sel = 0;
  bit          t_mapped = 1'b0;
  bit          t_err = 1'b0;
  bit          t_stray = 1'b0;
  bit          t_we = 1'b0;
  logic [31:0] t_rdata = '0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ackd = WAIT cycle (1-based) in which the slave acks; 0 means never.
  task automatic model(input logic [31:0] addr, input bit we, input int ackd);
    t_sel    = int'((addr / 128) % 4);
    t_mapped = (t_sel < NS);
    if (!t_mapped) begin
      t_lat = 1; t_err = 1'b1; t_rdata = '0;
    end else if (ackd >= 1 && ackd <= TO) begin
      t_lat = ackd + 1; t_err = 1'b0; t_rdata = we ? 32'h0 : sdata[t_sel];
    end else begin
      t_lat = TO + 1; t_err = 1'b1; t_rdata = '0;
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [NS-1:0] e_req;
    bit            e_rdy;
    int            k;
    if (rst) begin
      k     = cyc - t_start;
      e_req = '0;
      e_rdy = 1'b0;
      if (t_active) begin
        if (t_mapped && k >= 1 && k < t_lat) e_req[t_sel] = 1'b1;
        e_rdy = (k == t_lat);
      end
      chk("s_req", 32'(s_req), 32'(e_req));
      chk("cpu_ready", 32'(cpu_ready), 32'(e_rdy));
      chk("cpu_err", 32'(cpu_err), 32'(e_rdy && t_err));
      chk("cpu_rdata", cpu_rdata, e_rdy ? t_rdata : 32'h0);
      if (e_req != '0) begin
        chk("s_addr", s_addr, t_addr);
        chk("s_we", 32'(s_we), 32'(t_we));
        chk("s_wdata", s_wdata, t_wdata);
      end
    end
  end

  // Slave responder; stray mode also acks every slave in the idle sample
  // cycle and every non-selected slave afterwards.
  always @(negedge clk) begin : ackdrv
    int k;
    #2;
    s_ack = '0;
    if (t_active && rst) begin
      k = cyc - t_start;
      if (t_stray) begin
        s_ack = '1;
        if (k != 0 && t_mapped) s_ack[t_sel] = 1'b0;
      end
      if (t_mapped && t_ackd >= 1 && k == t_ackd) s_ack[t_sel] = 1'b1;
    end
  end

  task automatic txn(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                     input int ackd, input bit stray, input bit b2b, output int req_cycles);
    bit got;
    if (!b2b) begin
      @(negedge clk);
      #1;
    end
    model(addr, we, ackd);
    t_addr = addr; t_we = we; t_wdata = wdata; t_ackd = ackd; t_stray = stray;
    t_start  = b2b ? cyc + 1 : cyc;
    t_active = 1'b1;
    cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_wdata = wdata;
    req_cycles = 0;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (s_req != '0) req_cycles++;
      if (cpu_ready) got = 1'b1;
    end
    if (!got) chk("ready_seen", 32'd0, 32'd1);
    else      chk("latency", 32'(cyc - t_start), 32'(t_lat));
`ifdef DECODE_ERR_CAPTURE_EN
    if (t_err) begin
      exp_eaddr = addr;
      if (exp_ecnt < 255) exp_ecnt++;
    end
    chk("err_addr", err_addr, exp_eaddr);
    chk("err_cnt", 32'(err_cnt), 32'(exp_ecnt));
`endif
    #1;
    cpu_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int rc;
    sdata[0] = 32'h0BAD_F00D;
    sdata[1] = 32'hDEAD_BEEF;
    sdata[2] = 32'hCAFE_1234;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_s_req", 32'(s_req), 32'h0);
    chk("rst_s_we", 32'(s_we), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_err", 32'(cpu_err), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // Minimum-latency read of slave 1.
    txn(32'h0000_0080, 1'b0, 32'h0, 1, 1'b0, 1'b0, rc);
    chk("r21_lat", 32'(cyc - t_start), 32'd2);
    chk("r21_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("r21_err", 32'(cpu_err), 32'd0);

    // Write slave 2, ack in the fifth WAIT cycle.
    txn(32'h0000_0104, 1'b1, 32'h1234_5678, 5, 1'b0, 1'b0, rc);
    chk("r22_req_cycles", 32'(rc), 32'd5);
    chk("r22_s_wdata", s_wdata, 32'h1234_5678);
    chk("r22_err", 32'(cpu_err), 32'd0);
    chk("r22_rdata", cpu_rdata, 32'd0);

    // Unmapped select 3.
    txn(32'h0000_0180, 1'b0, 32'h0, 1, 1'b0, 1'b0, rc);
    chk("r23_req_cycles", 32'(rc), 32'd0);
    chk("r23_err", 32'(cpu_err), 32'd1);
    chk("r23_rdata", cpu_rdata, 32'd0);

    // Slave 0 never acks while others (and it, during idle) ack spuriously.
    txn(32'h0000_0000, 1'b0, 32'h0, 0, 1'b1, 1'b0, rc);
    chk("r24_req_cycles", 32'(rc), 32'd15);
    chk("r24_err", 32'(cpu_err), 32'd1);
    chk("r24_rdata", cpu_rdata, 32'd0);

    // Ack coincides with timeout: ack wins.
    txn(32'h0000_0100, 1'b0, 32'h0, 15, 1'b0, 1'b0, rc);
    chk("r09_lat", 32'(cyc - t_start), 32'd16);
    chk("r09_err", 32'(cpu_err), 32'd0);
    chk("r09_rdata", cpu_rdata, 32'hCAFE_1234);

    // Back-to-back accesses with high address bits set and stray acks.
    txn(32'h0000_0004, 1'b0, 32'h0, 2, 1'b0, 1'b0, rc);
    txn(32'hFFFF_FE80, 1'b1, 32'hA5A5_5A5A, 1, 1'b1, 1'b1, rc);
    txn(32'h0000_0380, 1'b1, 32'h1111_2222, 3, 1'b0, 1'b1, rc);
    txn(32'h0000_0180 - 32'h80, 1'b0, 32'h0, 4, 1'b1, 1'b1, rc);
    chk("b2b_rdata", cpu_rdata, 32'hCAFE_1234);

    // Reset in the third WAIT cycle aborts with no response.
    @(negedge clk); #1;
    model(32'h0000_0000, 1'b0, 0);
    t_addr = 32'h0; t_we = 1'b0; t_wdata = 32'h0; t_ackd = 0; t_stray = 1'b0;
    t_start = cyc; t_active = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h0; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("r25_pre_req", 32'(s_req), 32'h1);
    rst = 1'b0;
    t_active = 1'b0;
    #1;
    chk("r25_s_req", 32'(s_req), 32'h0);
    chk("r25_ready", 32'(cpu_ready), 32'h0);
    chk("r25_s_addr", s_addr, 32'h0);
    cpu_req = 1'b0;
`ifdef DECODE_ERR_CAPTURE_EN
    exp_ecnt = 0;
    exp_eaddr = '0;
    chk("r25_err_cnt", 32'(err_cnt), 32'h0);
`endif
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    txn(32'h0000_0080, 1'b0, 32'h0, 3, 1'b0, 1'b0, rc);
    chk("r25_after_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("r25_after_lat", 32'(cyc - t_start), 32'd4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
